// File: rtl/note_sequencer.sv
// note_sequencer: stores up to DEPTH 4-bit note entries and plays them back in
// write order, presenting each entry for STEP_CYCLES clock cycles.
// Build option: define NOTE_SEQ_LOOP_EN to loop playback forever.
//   Without it, playback stops after the last entry.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_valid, wr_data   append one entry {tom, nota[2:0]}
//   wr_ready            write accepted this cycle (IDLE and memory not full)
//   clear               empty the memory (IDLE only)
//   start, pause, stop  playback control (pause is a level)
//   tom_out, notas_out  current note toward the display decoder
//   note_valid          high while a note is being presented
//   step_idx            index of the entry being presented
//   count               number of stored entries
//   done                one-cycle pulse at each end of sequence
module note_sequencer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned STEP_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [3:0]                 wr_data,
    output logic                       wr_ready,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       stop,
    output logic                       tom_out,
    output logic [2:0]                 notas_out,
    output logic                       note_valid,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       done
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned TW = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [3:0]      mem [DEPTH];

    logic            wr_fire;
    logic            last_tick;
    logic            last_entry;
    logic [IW-1:0]   next_idx;

    // Writes only land in IDLE with free space; clear takes precedence.
    assign wr_ready   = (state == S_IDLE) && (count < CW'(DEPTH));
    assign wr_fire    = wr_valid && wr_ready && !clear;
    assign last_tick  = (timer == TW'(STEP_CYCLES - 1));
    assign last_entry = ({1'b0, step_idx} == (count - CW'(1)));
    assign next_idx   = step_idx + IW'(1);

    // Note storage, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[count[IW-1:0]] <= wr_data;
        end
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            timer      <= '0;
            step_idx   <= '0;
            note_valid <= 1'b0;
            tom_out    <= 1'b0;
            notas_out  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        count <= '0;
                    end else begin
                        if (wr_fire) begin
                            count <= count + CW'(1);
                        end
                        // count>0 is sampled before any same-cycle write lands.
                        if (start && (count != '0)) begin
                            state      <= S_PLAY;
                            timer      <= '0;
                            step_idx   <= '0;
                            note_valid <= 1'b1;
                            tom_out    <= mem[0][3];
                            notas_out  <= mem[0][2:0];
                        end
                    end
                end

                S_PLAY: begin
                    if (stop) begin
                        state      <= S_IDLE;
                        timer      <= '0;
                        step_idx   <= '0;
                        note_valid <= 1'b0;
                        tom_out    <= 1'b0;
                        notas_out  <= '0;
                    end else if (pause) begin
                        // Freeze on this edge: timer does not advance.
                        state <= S_PAUSE;
                    end else if (last_tick) begin
                        timer <= '0;
                        if (last_entry) begin
                            done <= 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                            step_idx  <= '0;
                            tom_out   <= mem[0][3];
                            notas_out <= mem[0][2:0];
`else
                            state      <= S_IDLE;
                            step_idx   <= '0;
                            note_valid <= 1'b0;
                            tom_out    <= 1'b0;
                            notas_out  <= '0;
`endif
                        end else begin
                            step_idx  <= next_idx;
                            tom_out   <= mem[next_idx][3];
                            notas_out <= mem[next_idx][2:0];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                S_PAUSE: begin
                    if (stop) begin
                        state      <= S_IDLE;
                        timer      <= '0;
                        step_idx   <= '0;
                        note_valid <= 1'b0;
                        tom_out    <= 1'b0;
                        notas_out  <= '0;
                    end else if (!pause) begin
                        state <= S_PLAY;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    timer      <= '0;
                    step_idx   <= '0;
                    note_valid <= 1'b0;
                    tom_out    <= 1'b0;
                    notas_out  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer (DEPTH=8, STEP_CYCLES=4).
module tb_note_sequencer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned STEP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic       wr_ready;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic       tom_out;
    logic [2:0] notas_out;
    logic       note_valid;
    logic [2:0] step_idx;
    logic [3:0] count;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    note_sequencer #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clear      (clear),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .tom_out    (tom_out),
        .notas_out  (notas_out),
        .note_valid (note_valid),
        .step_idx   (step_idx),
        .count      (count),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Output vector layout: {count[3:0], wr_ready, note_valid, tom, notas[2:0], step_idx[2:0], done}
    function automatic logic [13:0] ev(int cnt, bit rdy, bit nv, bit tom, int notas, int idx, bit dn);
        return {4'(cnt), rdy, nv, tom, 3'(notas), 3'(idx), dn};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {count, wr_ready, note_valid, tom_out, notas_out, step_idx, done};
    endfunction

    task automatic chk(string name, logic [13:0] act, logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 idle, 1 playing, 2 paused. Entries kept as a queue in write order.
    logic [3:0] mq[$];
    int  m_mode = 0;
    int  m_idx  = 0;
    int  m_el   = 0;   // active play cycles already spent on current entry
    bit  m_done = 0;

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_idx = 0; m_el = 0; m_done = 0;
    endtask

    task automatic model_tick();
        int old_size;
        old_size = mq.size();
        m_done = 0;
        if (m_mode == 0) begin
            if (clear) begin
                mq.delete();
            end else begin
                if (wr_valid && old_size < DEPTH) mq.push_back(wr_data);
                if (start && old_size > 0) begin
                    m_mode = 1; m_idx = 0; m_el = 0;
                end
            end
        end else if (stop) begin
            m_mode = 0; m_idx = 0; m_el = 0;
        end else if (m_mode == 2) begin
            if (!pause) m_mode = 1;
        end else if (pause) begin
            m_mode = 2;
        end else begin
            m_el++;
            if (m_el == STEP) begin
                m_el = 0;
                if (m_idx == mq.size() - 1) begin
                    m_done = 1;
                    m_idx  = 0;
`ifndef NOTE_SEQ_LOOP_EN
                    m_mode = 0;
`endif
                end else begin
                    m_idx++;
                end
            end
        end
    endtask

    function automatic logic [13:0] model_vec();
        bit nv;
        logic [3:0] e;
        nv = (m_mode != 0);
        e  = nv ? mq[m_idx] : 4'h0;
        return ev(mq.size(), (m_mode == 0) && (mq.size() < DEPTH), nv, e[3], int'(e[2:0]),
                  nv ? m_idx : 0, m_done);
    endfunction

    // ---------------- helpers ----------------
    task automatic idle_inputs();
        wr_valid = 0; wr_data = 0; clear = 0; start = 0; pause = 0; stop = 0;
    endtask

    task automatic cyc(string nm);
        model_tick();
        @(posedge clk);
        #1;
        chk(nm, dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        chk("reset_state", dut_vec(), ev(0, 1, 0, 0, 0, 0, 0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic write_entry(logic [3:0] d);
        idle_inputs();
        wr_valid = 1; wr_data = d;
        cyc("write");
        idle_inputs();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       wv;
        logic [3:0] wd;
        logic       st;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // Write 3, 9, 5 then start and play through the sequence.
        tbl[0] = '{1'b1, 4'd3, 1'b0, ev(1, 1, 0, 0, 0, 0, 0)};
        tbl[1] = '{1'b1, 4'd9, 1'b0, ev(2, 1, 0, 0, 0, 0, 0)};
        tbl[2] = '{1'b1, 4'd5, 1'b0, ev(3, 1, 0, 0, 0, 0, 0)};
        tbl[3] = '{1'b0, 4'd0, 1'b1, ev(3, 0, 1, 0, 3, 0, 0)};
        for (int i = 4; i < 7; i++)   tbl[i] = '{1'b0, 4'd0, 1'b0, ev(3, 0, 1, 0, 3, 0, 0)};
        for (int i = 7; i < 11; i++)  tbl[i] = '{1'b0, 4'd0, 1'b0, ev(3, 0, 1, 1, 1, 1, 0)};
        for (int i = 11; i < 15; i++) tbl[i] = '{1'b0, 4'd0, 1'b0, ev(3, 0, 1, 0, 5, 2, 0)};
`ifdef NOTE_SEQ_LOOP_EN
        tbl[15] = '{1'b0, 4'd0, 1'b0, ev(3, 0, 1, 0, 3, 0, 1)};
        tbl[16] = '{1'b0, 4'd0, 1'b0, ev(3, 0, 1, 0, 3, 0, 0)};
`else
        tbl[15] = '{1'b0, 4'd0, 1'b0, ev(3, 1, 0, 0, 0, 0, 1)};
        tbl[16] = '{1'b0, 4'd0, 1'b0, ev(3, 1, 0, 0, 0, 0, 0)};
`endif

        do_reset();
        for (int i = 0; i < 17; i++) begin
            idle_inputs();
            wr_valid = tbl[i].wv;
            wr_data  = tbl[i].wd;
            start    = tbl[i].st;
            @(posedge clk);
            #1;
            chk($sformatf("table_row%0d", i), dut_vec(), tbl[i].exp);
        end

        // Fill memory, overflow attempt, then clear.
        do_reset();
        for (int i = 0; i < 8; i++) write_entry(4'($urandom_range(0, 15)));
        wr_valid = 1; wr_data = 4'hF;
        cyc("ninth_write");
        chk("full_count_ready", {10'd0, count, wr_ready}, {10'd0, 4'd8, 1'b0});
        idle_inputs();
        clear = 1; wr_valid = 1; wr_data = 4'h7;
        cyc("clear_wins");
        chk("cleared_count_ready", {10'd0, count, wr_ready}, {10'd0, 4'd0, 1'b1});
        idle_inputs();

        // Start with an empty memory is ignored.
        do_reset();
        start = 1;
        cyc("start_empty");
        chk("start_empty_idle", dut_vec(), ev(0, 1, 0, 0, 0, 0, 0));
        idle_inputs();
        cyc("start_empty_after");

        // Pause on entry 0 after timer reaches 2.
        do_reset();
        write_entry(4'hA);
        write_entry(4'h6);
        start = 1;
        cyc("pz_start");
        idle_inputs();
        cyc("pz_t1");
        cyc("pz_t2");
        pause = 1;
        for (int i = 0; i < 5; i++) begin
            cyc("pz_hold");
            chk("pz_frozen", dut_vec(), ev(2, 0, 1, 1, 2, 0, 0));
        end
        pause = 0;
        cyc("pz_rel1");
        chk("pz_entry0_a", {11'd0, step_idx}, 14'd0);
        cyc("pz_rel2");
        chk("pz_entry0_b", {11'd0, step_idx}, 14'd0);
        cyc("pz_rel3");
        chk("pz_entry1", dut_vec(), ev(2, 0, 1, 0, 6, 1, 0));

        // Stop and pause together, then restart from entry 0.
        do_reset();
        write_entry(4'h3);
        write_entry(4'hC);
        start = 1;
        cyc("sp_start");
        idle_inputs();
        cyc("sp_t1");
        cyc("sp_t2");
        stop = 1; pause = 1;
        cyc("sp_stop");
        chk("sp_idle", dut_vec(), ev(2, 1, 0, 0, 0, 0, 0));
        idle_inputs();
        start = 1;
        cyc("sp_restart");
        chk("sp_restart_entry0", dut_vec(), ev(2, 0, 1, 0, 3, 0, 0));
        idle_inputs();
        cyc("sp_play");

        // Asynchronous reset mid-step forces outputs low at once.
        #2;
        rst_n = 0;
        #1;
        chk("async_reset", dut_vec(), ev(0, 1, 0, 0, 0, 0, 0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc("post_reset_idle");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            wr_valid = ($urandom_range(0, 99) < 30);
            wr_data  = 4'($urandom_range(0, 15));
            clear    = ($urandom_range(0, 99) < 3);
            start    = ($urandom_range(0, 99) < 10);
            pause    = ($urandom_range(0, 99) < 10);
            stop     = ($urandom_range(0, 99) < 2);
            cyc("random");
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, 8, number of note entries in the sequence memory (power of two, 2..16).
REQ-002 Parameter STEP_CYCLES, 16, clock cycles each note is presented (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 wr_valid  input  1  write request for one sequence entry.
REQ-006 wr_data  input  4  entry {tom, nota[2:0]}: bit 3 = tone/sharp flag, bits 2:0 = note code.
REQ-007 wr_ready  output  1  high when a write is accepted this cycle.
REQ-008 clear  input  1  empties the sequence memory (IDLE only).
REQ-009 start  input  1  begins playback from entry 0.
REQ-010 pause  input  1  level; freezes playback while high.
REQ-011 stop  input  1  aborts playback.
REQ-012 tom_out  output  1  tone flag to the display decoder.
REQ-013 notas_out  output  3  note code to the display decoder.
REQ-014 note_valid  output  1  high while tom_out/notas_out carry a playing note.
REQ-015 step_idx  output  log2(DEPTH)  index of the entry being presented.
REQ-016 count  output  log2(DEPTH)+1  number of stored entries.
REQ-017 done  output  1  one-cycle pulse at natural end of sequence.

Function
REQ-018 States SHALL be IDLE, PLAY, PAUSE; encoding free.
REQ-019 wr_ready SHALL equal (state==IDLE && count<DEPTH); a write with wr_valid&&wr_ready SHALL store wr_data at address count and increment count next cycle.
REQ-020 clear in IDLE SHALL set count to 0 next cycle; clear outside IDLE SHALL be ignored; clear with wr_valid in the same cycle SHALL win (no write).
REQ-021 start in IDLE with count>0 SHALL enter PLAY next cycle with step_idx=0, step timer=0, note_valid=1 and outputs showing entry 0; start with count==0 or outside IDLE SHALL be ignored.
REQ-022 In PLAY the step timer SHALL count 0..STEP_CYCLES-1; each entry SHALL be presented for exactly STEP_CYCLES cycles, then step_idx SHALL advance by one.
REQ-023 When the timer expires on entry count-1 (end of sequence), behaviour SHALL follow REQ-031/REQ-032.
REQ-024 pause high in PLAY SHALL enter PAUSE next cycle, freezing timer, step_idx and outputs (note_valid stays 1); pause low in PAUSE SHALL return to PLAY, resuming the timer where frozen.
REQ-025 stop in PLAY or PAUSE SHALL enter IDLE next cycle with note_valid=0, tom_out=0, notas_out=0, step_idx=0; count and memory SHALL be preserved; no done pulse.
REQ-026 Priority on simultaneous inputs: stop > pause > start; stop coinciding with end of sequence SHALL suppress done.
REQ-027 In IDLE outputs SHALL be note_valid=0, tom_out=0, notas_out=0, step_idx=0.
REQ-028 Entries written SHALL be played in write order; stored data SHALL not be altered by playback.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, count=0, timer=0, step_idx=0, note_valid=0, tom_out=0, notas_out=0, done=0, wr_ready=1; memory contents need not reset.
REQ-030 Reset asserted mid-playback SHALL abort without a done pulse; after release the block SHALL stay in IDLE until a new start.

Configuration
REQ-031 Macro NOTE_SEQ_LOOP_EN defined: at end of sequence step_idx SHALL wrap to 0 and PLAY SHALL continue indefinitely; done SHALL pulse for one cycle at each wrap.
REQ-032 Macro NOTE_SEQ_LOOP_EN undefined: at end of sequence the block SHALL enter IDLE next cycle, pulse done for one cycle in that cycle, and drive IDLE outputs.

Verification
REQ-033 DEPTH=8, STEP_CYCLES=4; write 3,9,5 then start -> notas_out/tom_out show 011/0 for 4 cycles, 001/1 for 4, 101/0 for 4; without loop done pulses once, then note_valid=0.
REQ-034 Write 8 entries -> count=8, wr_ready=0; a 9th wr_valid is not stored; clear -> count=0, wr_ready=1.
REQ-035 Start with count=0 -> state stays IDLE, note_valid=0, no done.
REQ-036 Play 2 entries, pause high 5 cycles after timer=2 on entry 0 -> outputs frozen 5 cycles, entry 0 then lasts 2 more cycles after release.
REQ-037 Assert stop and pause in the same cycle during PLAY -> IDLE next cycle, no done; restart plays from entry 0 with stored data intact.
REQ-038 With NOTE_SEQ_LOOP_EN, 2 entries -> step_idx sequence 0,1,0,1 with done pulsing every 8 cycles; rst_n low mid-step -> outputs zero immediately.
